// File: rtl/scoreboard_issue_ctrl_pkg.sv
// scoreboard_issue_ctrl_pkg: shared widths, FU identifiers and default per-FU latencies.
package scoreboard_issue_ctrl_pkg;
   localparam int REG_W = 5;
   localparam int FU_ALU = 1;
   localparam int FU_MEM = 2;
   localparam int FU_MUL = 3;
   localparam int FU_DIV = 4;
   localparam int FU_JUMP = 5;
   localparam int LAT_ALU = 1;
   localparam int LAT_MEM = 2;
   localparam int LAT_MUL = 4;
   localparam int LAT_DIV = 8;
   localparam int LAT_JUMP = 1;
   typedef enum logic [2:0] {
      IDX_ALU = 3'(FU_ALU - 1),
      IDX_MEM = 3'(FU_MEM - 1),
      IDX_MUL = 3'(FU_MUL - 1),
      IDX_DIV = 3'(FU_DIV - 1),
      IDX_JUMP = 3'(FU_JUMP - 1)
   } fu_idx_e;
   function automatic int fu_index(input int fu_id);
      return fu_id - 1;
   endfunction
endpackage

// File: rtl/fu_status_slot.sv
// fu_status_slot: per-FU busy flag, latency countdown and latched destination; done when the countdown reaches zero.
module fu_status_slot
   import scoreboard_issue_ctrl_pkg::*;
#(
   parameter int LAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             grant,
   input  logic [LAT_W-1:0] lat,
   input  logic [REG_W-1:0] rd_in,
   input  logic             wr_in,
   output logic             busy,
   output logic [REG_W-1:0] rd,
   output logic             wr,
   output logic             done
);
   logic busy_q, busy_d, wr_q, wr_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic [REG_W-1:0] rd_q, rd_d;
   // a zero latency behaves like one: done in the first cycle after issue
   always_comb begin
      busy_d = load ? 1'b1 : (grant ? 1'b0 : busy_q);
      cnt_d = load ? ((lat == '0) ? '0 : lat - 1'b1) : ((busy_q && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q);
      rd_d = load ? rd_in : rd_q;
      wr_d = load ? wr_in : wr_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q <= '0;
         rd_q <= '0;
         wr_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q <= cnt_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
      end
   end
   assign busy = busy_q;
   assign rd = rd_q;
   assign wr = wr_q;
   assign done = busy_q && cnt_q == '0;
endmodule

// File: rtl/scoreboard_issue_ctrl.sv
// scoreboard_issue_ctrl: issue/writeback scoreboard over NUM_FU slots with a register result-status table.
// SCOREBOARD_WB_BYPASS_EN lets a RAW hazard clear against the writeback granted in the same cycle.
module scoreboard_issue_ctrl
   import scoreboard_issue_ctrl_pkg::*;
#(
   parameter int NUM_FU = 5,
   parameter int FU_IDX_W = 3,
   parameter int LAT_W = 4,
   parameter int NUM_REGS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   input  logic [FU_IDX_W-1:0] issue_fu,
   input  logic [REG_W-1:0]    issue_rd,
   input  logic                issue_wr,
   input  logic [REG_W-1:0]    issue_rs1,
   input  logic [REG_W-1:0]    issue_rs2,
   input  logic                issue_use_rs1,
   input  logic                issue_use_rs2,
   input  logic [LAT_W-1:0]    issue_lat,
   output logic                issue_ready,
   output logic [NUM_FU-1:0]   fu_en,
   output logic [NUM_FU-1:0]   fu_busy,
   output logic                wb_valid,
   output logic [FU_IDX_W-1:0] wb_fu,
   output logic [REG_W-1:0]    wb_rd,
   output logic                wb_we
);
   logic [NUM_FU-1:0] done, gnt, slot_wr;
   logic [REG_W-1:0] slot_rd [NUM_FU];
   logic [2**FU_IDX_W-1:0] busy_pad;
   logic [NUM_REGS-1:0] st_valid_q, st_valid_d;
   logic [FU_IDX_W-1:0] st_fu_q [NUM_REGS];
   logic [FU_IDX_W-1:0] st_fu_d [NUM_REGS];
   logic waw, raw1, raw2, byp1, byp2;
   for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
      fu_status_slot #(.LAT_W(LAT_W)) u_slot (
         .clk(clk), .rst(rst), .load(fu_en[g]), .grant(gnt[g]), .lat(issue_lat),
         .rd_in(issue_rd), .wr_in(issue_wr), .busy(fu_busy[g]), .rd(slot_rd[g]),
         .wr(slot_wr[g]), .done(done[g])
      );
   end
   // descending scan so the lowest-index done FU is the last to assign
   always_comb begin
      gnt = '0;
      wb_valid = 1'b0;
      wb_fu = '0;
      wb_rd = '0;
      wb_we = 1'b0;
      for (int i = NUM_FU - 1; i >= 0; i--) begin
         if (done[i] && !rst) begin
            gnt = '0;
            gnt[i] = 1'b1;
            wb_valid = 1'b1;
            wb_fu = FU_IDX_W'(i);
            wb_rd = slot_rd[i];
            wb_we = slot_wr[i];
         end
      end
   end
   always_comb begin
      busy_pad = '0;
      busy_pad[NUM_FU-1:0] = fu_busy;
`ifdef SCOREBOARD_WB_BYPASS_EN
      byp1 = wb_we && wb_rd == issue_rs1;
      byp2 = wb_we && wb_rd == issue_rs2;
`else
      byp1 = 1'b0;
      byp2 = 1'b0;
`endif
      raw1 = issue_use_rs1 && issue_rs1 != '0 && st_valid_q[issue_rs1] && !byp1;
      raw2 = issue_use_rs2 && issue_rs2 != '0 && st_valid_q[issue_rs2] && !byp2;
      waw = issue_wr && issue_rd != '0 && st_valid_q[issue_rd];
      issue_ready = !rst && issue_valid && 32'(issue_fu) < NUM_FU && !busy_pad[issue_fu] && !waw && !raw1 && !raw2;
      for (int i = 0; i < NUM_FU; i++) fu_en[i] = issue_ready && issue_fu == FU_IDX_W'(i);
   end
   // issue is applied after the grant clear so a same-register collision keeps the new owner
   always_comb begin
      st_valid_d = st_valid_q;
      st_fu_d = st_fu_q;
      if (wb_valid && st_valid_q[wb_rd] && st_fu_q[wb_rd] == wb_fu) st_valid_d[wb_rd] = 1'b0;
      if (issue_ready && issue_wr && issue_rd != '0) begin
         st_valid_d[issue_rd] = 1'b1;
         st_fu_d[issue_rd] = issue_fu;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) st_valid_q <= '0;
      else st_valid_q <= st_valid_d;
      st_fu_q <= st_fu_d;
   end
endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// tb_scoreboard_issue_ctrl: directed scenarios plus randomized traffic against a completion-time reference model.
module tb_scoreboard_issue_ctrl;
  localparam int NUM_FU = 5;
  localparam int FU_IDX_W = 3;
  localparam int LAT_W = 4;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, issue_valid, issue_wr, issue_use_rs1, issue_use_rs2;
  logic [FU_IDX_W-1:0] issue_fu;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  logic [LAT_W-1:0] issue_lat;
  logic issue_ready, wb_valid, wb_we;
  logic [NUM_FU-1:0] fu_en, fu_busy;
  logic [FU_IDX_W-1:0] wb_fu;
  logic [4:0] wb_rd;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  scoreboard_issue_ctrl #(.NUM_FU(NUM_FU), .FU_IDX_W(FU_IDX_W), .LAT_W(LAT_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_rd(issue_rd),
    .issue_wr(issue_wr), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_lat(issue_lat), .issue_ready(issue_ready), .fu_en(fu_en),
    .fu_busy(fu_busy), .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_rd(wb_rd), .wb_we(wb_we)
  );
  task automatic set_issue(input int fu, input int rd, input bit wr, input int rs1, input int rs2,
                           input bit u1, input bit u2, input int lat);
    issue_valid = 1'b1;
    issue_fu = FU_IDX_W'(fu);
    issue_rd = 5'(rd);
    issue_wr = wr;
    issue_rs1 = 5'(rs1);
    issue_rs2 = 5'(rs2);
    issue_use_rs1 = u1;
    issue_use_rs2 = u2;
    issue_lat = LAT_W'(lat);
  endtask
  task automatic idle();
    issue_valid = 1'b0;
    issue_wr = 1'b0;
    issue_use_rs1 = 1'b0;
    issue_use_rs2 = 1'b0;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    idle();
    repeat (12) next();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle();
    issue_fu = '0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0; issue_lat = '0;
    repeat (2) next();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fu_busy !== '0 || wb_valid !== 1'b0 || fu_en !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b wb_valid=%b fu_en=%b expected 0/0/0", fu_busy, wb_valid, fu_en);
    end
    next();
    set_issue(6, 3, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b0 || fu_en !== '0) begin
      failures++;
      $display("FAIL bad_fu_index ready=%b fu_en=%b expected 0/00000", issue_ready, fu_en);
    end
    next();
    drain();
  endtask
  task automatic test_basic();
    set_issue(2, 5, 1, 0, 0, 0, 0, 3);
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || fu_en !== 5'b00100) begin
      failures++;
      $display("FAIL basic_issue ready=%b fu_en=%b expected 1/00100", issue_ready, fu_en);
    end
    next();
    idle();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (wb_valid !== (c == 3)) begin
        failures++;
        $display("FAIL basic_wb_time c=%0d wb_valid=%b expected %b", c, wb_valid, c == 3);
      end
      if (c == 1) begin
        checks++;
        if (fu_en !== '0 || fu_busy[2] !== 1'b1) begin
          failures++;
          $display("FAIL basic_pulse fu_en=%b busy=%b expected 00000/busy2", fu_en, fu_busy);
        end
      end
      if (c == 3) begin
        checks++;
        if (wb_fu !== 3'd2 || wb_rd !== 5'd5 || wb_we !== 1'b1) begin
          failures++;
          $display("FAIL basic_wb fu=%0d rd=%0d we=%b expected 2/5/1", wb_fu, wb_rd, wb_we);
        end
      end
      if (c == 4) begin
        checks++;
        if (fu_busy !== '0) begin
          failures++;
          $display("FAIL basic_busy_clear busy=%b expected 00000", fu_busy);
        end
      end
      next();
    end
    drain();
  endtask
  task automatic test_busy_stall();
    set_issue(2, 6, 1, 0, 0, 0, 0, 2);
    next();
    set_issue(2, 8, 1, 0, 0, 0, 0, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (issue_ready !== (c == 3)) begin
        failures++;
        $display("FAIL busy_stall c=%0d ready=%b expected %b", c, issue_ready, c == 3);
      end
      if (c == 2) begin
        checks++;
        if (wb_valid !== 1'b1 || wb_fu !== 3'd2 || wb_rd !== 5'd6) begin
          failures++;
          $display("FAIL busy_grant valid=%b fu=%0d rd=%0d expected 1/2/6", wb_valid, wb_fu, wb_rd);
        end
      end
      next();
    end
    idle();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_fu !== 3'd2 || wb_rd !== 5'd8) begin
      failures++;
      $display("FAIL busy_reissue_wb valid=%b fu=%0d rd=%0d expected 1/2/8", wb_valid, wb_fu, wb_rd);
    end
    drain();
  endtask
  task automatic test_raw();
    int issued_at;
    issued_at = -1;
    set_issue(3, 7, 1, 0, 0, 0, 0, 4);
    next();
    set_issue(0, 9, 1, 7, 0, 1, 0, 1);
    for (int c = 1; c <= 10 && issued_at < 0; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_fu !== 3'd3) begin
          failures++;
          $display("FAIL raw_producer_wb valid=%b fu=%0d rd=%0d expected 1/3/7", wb_valid, wb_fu, wb_rd);
        end
      end
      if (issue_ready === 1'b1) issued_at = c;
      next();
    end
    idle();
    checks++;
    if (issued_at != (BYP ? 4 : 5)) begin
      failures++;
      $display("FAIL raw_issue_cycle got=%0d expected %0d", issued_at, BYP ? 4 : 5);
    end
    drain();
  endtask
  task automatic test_priority();
    set_issue(1, 10, 1, 0, 0, 0, 0, 2);
    next();
    set_issue(4, 11, 1, 0, 0, 0, 0, 1);
    next();
    idle();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_fu !== 3'd1 || wb_rd !== 5'd10 || wb_we !== 1'b1) begin
      failures++;
      $display("FAIL prio_first valid=%b fu=%0d rd=%0d we=%b expected 1/1/10/1", wb_valid, wb_fu, wb_rd, wb_we);
    end
    next();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_fu !== 3'd4 || wb_rd !== 5'd11 || wb_we !== 1'b1) begin
      failures++;
      $display("FAIL prio_second valid=%b fu=%0d rd=%0d we=%b expected 1/4/11/1", wb_valid, wb_fu, wb_rd, wb_we);
    end
    drain();
  endtask
  task automatic test_x0();
    set_issue(0, 0, 1, 0, 0, 0, 0, 2);
    next();
    set_issue(1, 0, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_no_stall ready=%b expected 1", issue_ready);
    end
    next();
    idle();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_fu !== 3'd0 || wb_rd !== 5'd0 || wb_we !== 1'b1) begin
      failures++;
      $display("FAIL x0_wb valid=%b fu=%0d rd=%0d we=%b expected 1/0/0/1", wb_valid, wb_fu, wb_rd, wb_we);
    end
    next();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b1 || wb_fu !== 3'd1 || wb_we !== 1'b0) begin
      failures++;
      $display("FAIL x0_nowrite_wb valid=%b fu=%0d we=%b expected 1/1/0", wb_valid, wb_fu, wb_we);
    end
    drain();
  endtask
  task automatic test_reset_mid();
    set_issue(0, 12, 1, 0, 0, 0, 0, 8);
    next();
    set_issue(3, 13, 1, 0, 0, 0, 0, 8);
    next();
    idle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_wb wb_valid=%b expected 0", wb_valid);
    end
    next();
    rst = 1'b0;
    set_issue(1, 12, 1, 12, 13, 1, 1, 1);
    @(negedge clk);
    checks++;
    if (fu_busy !== '0 || wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_clear busy=%b wb_valid=%b ready=%b expected 00000/0/1", fu_busy, wb_valid, issue_ready);
    end
    next();
    drain();
  endtask
  task automatic test_random();
    bit m_busy [NUM_FU];
    int m_done_at [NUM_FU];
    int m_rd [NUM_FU];
    bit m_wr [NUM_FU];
    int owner [32];
    int cyc, g, fu, rs1, rs2, rd;
    bit e_valid, e_we, e_ready, raw, waw;
    logic [NUM_FU-1:0] e_busy;
    rst = 1'b1;
    idle();
    next();
    rst = 1'b0;
    for (int f = 0; f < NUM_FU; f++) m_busy[f] = 1'b0;
    for (int r = 0; r < 32; r++) owner[r] = -1;
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      fu = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      set_issue(fu, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 6));
      issue_valid = ($urandom_range(0, 3) != 0);
      rd = int'(issue_rd); rs1 = int'(issue_rs1); rs2 = int'(issue_rs2);
      g = -1;
      for (int f = NUM_FU - 1; f >= 0; f--) if (m_busy[f] && cyc >= m_done_at[f]) g = f;
      e_valid = !rst && g >= 0;
      e_we = e_valid && m_wr[g];
      raw = (issue_use_rs1 && rs1 != 0 && owner[rs1] >= 0 && !(BYP && e_we && m_rd[g] == rs1)) ||
            (issue_use_rs2 && rs2 != 0 && owner[rs2] >= 0 && !(BYP && e_we && m_rd[g] == rs2));
      waw = issue_wr && rd != 0 && owner[rd] >= 0;
      e_ready = issue_valid && fu < NUM_FU && !raw && !waw;
      if (e_ready) e_ready = !m_busy[fu];
      for (int f = 0; f < NUM_FU; f++) e_busy[f] = m_busy[f];
      @(negedge clk);
      checks++;
      if (wb_valid !== e_valid) begin
        failures++;
        $display("FAIL rnd_wb_valid n=%0d got=%b expected %b", n, wb_valid, e_valid);
      end
      checks++;
      if (fu_busy !== e_busy) begin
        failures++;
        $display("FAIL rnd_busy n=%0d got=%b expected %b", n, fu_busy, e_busy);
      end
      if (e_valid) begin
        checks++;
        if (wb_fu !== FU_IDX_W'(g) || wb_rd !== 5'(m_rd[g]) || wb_we !== e_we) begin
          failures++;
          $display("FAIL rnd_wb n=%0d fu=%0d rd=%0d we=%b expected %0d/%0d/%b", n, wb_fu, wb_rd, wb_we, g, m_rd[g], e_we);
        end
      end
      if (!rst) begin
        checks++;
        if (issue_ready !== e_ready || fu_en !== (e_ready ? NUM_FU'(1) << fu : '0)) begin
          failures++;
          $display("FAIL rnd_issue n=%0d ready=%b fu_en=%b expected ready %b", n, issue_ready, fu_en, e_ready);
        end
      end
      if (rst) begin
        for (int f = 0; f < NUM_FU; f++) m_busy[f] = 1'b0;
        for (int r = 0; r < 32; r++) owner[r] = -1;
      end else begin
        if (e_valid) begin
          m_busy[g] = 1'b0;
          if (owner[m_rd[g]] == g) owner[m_rd[g]] = -1;
        end
        if (e_ready) begin
          m_busy[fu] = 1'b1;
          m_done_at[fu] = cyc + ((issue_lat == 0) ? 1 : int'(issue_lat));
          m_rd[fu] = rd;
          m_wr[fu] = issue_wr;
          if (issue_wr && rd != 0) owner[rd] = fu;
        end
      end
      next();
      cyc++;
    end
    rst = 1'b0;
    drain();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_busy_stall();
    test_raw();
    test_priority();
    test_x0();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
